// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types for the UART transmit scheduler
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_TRAP = 1'b1;

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - byte source ports and transmitter handshake
interface uart_tx_sched_if;
  logic       s0_valid;
  logic [7:0] s0_data;
  logic       s0_last;
  logic       s0_ready;
  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_last;
  logic       s1_ready;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_busy;

  modport master (
    output s0_valid, s0_data, s0_last, input s0_ready,
    output s1_valid, s1_data, s1_last, input s1_ready,
    input uart_start, uart_data, output uart_busy
  );

  modport slave (
    input s0_valid, s0_data, s0_last, output s0_ready,
    input s1_valid, s1_data, s1_last, output s1_ready,
    output uart_start, uart_data, input uart_busy
  );
endinterface

// File: rtl/uart_tx_sched_fifo.sv
// rtl/uart_tx_sched_fifo.sv - sync_fifo: power-of-two synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - packet round-robin sharing of one UART transmitter between CPU and trap sources
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_sched_if.slave         bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] T_ONE = 1;

  tx_state_t   state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [7:0]  data_q, data_nx;
  logic        lock, gnt_q, rr;
  logic        gnt, gnt_valid, gnt_last;
  logic [7:0]  gnt_data, head;
  logic        push, pop, full, empty;

  // A locked grant holds until the last byte; ties go to the port not served last.
  always_comb begin
    if (lock)                              gnt = gnt_q;
    else if (bus.s0_valid && bus.s1_valid) gnt = rr;
    else if (bus.s1_valid)                 gnt = PORT_TRAP;
    else                                   gnt = PORT_CPU;
  end

  assign gnt_valid    = (gnt == PORT_TRAP) ? bus.s1_valid : bus.s0_valid;
  assign gnt_last     = (gnt == PORT_TRAP) ? bus.s1_last  : bus.s0_last;
  assign gnt_data     = (gnt == PORT_TRAP) ? bus.s1_data  : bus.s0_data;
  assign bus.s0_ready = (gnt == PORT_CPU)  && (lock || bus.s0_valid) && !full;
  assign bus.s1_ready = (gnt == PORT_TRAP) && (lock || bus.s1_valid) && !full;
  assign push         = gnt_valid && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock  <= 1'b0;
      gnt_q <= PORT_CPU;
      rr    <= PORT_CPU;
    end else if (push) begin
      if (gnt_last) begin
        lock <= 1'b0;
        rr   <= ~gnt;
      end else begin
        lock  <= 1'b1;
        gnt_q <= gnt;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (gnt_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      data_q <= data_nx;
    end
  end

  // Timer counts cycles since the start pulse so a silent transmitter frees us after BUSY_TIMEOUT.
  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    data_nx        = data_q;
    pop            = 1'b0;
    bus.uart_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nx = START;
          data_nx  = head;
          pop      = 1'b1;
        end
      end
      START: begin
        bus.uart_start = 1'b1;
        timer_nx       = T_ONE;
        state_nx       = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.uart_busy)                          state_nx = WAIT_DONE;
        else if (timer == TW'(BUSY_TIMEOUT - 1))    state_nx = IDLE;
        else                                        timer_nx = timer + T_ONE;
      end
      WAIT_DONE: begin
        if (!bus.uart_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.uart_data = data_q;
  assign idle          = empty && (state == IDLE) && !lock;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fifo_count;
  logic       idle;
  int         checks = 0;
  int         failures = 0;
  int         busy_len = 4;
  bit         busy_hold = 1'b0;
  int         busy_cnt = 0;
  int         cyc = 0;
  logic [7:0] tx_q[$];
  int         tx_t[$];

  uart_tx_sched_if bus ();

  uart_tx_sched #(.DEPTH(8), .BUSY_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for busy_len cycles after each start, or held high.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt      <= 0;
      bus.uart_busy <= busy_hold;
    end else if (bus.uart_start === 1'b1 && busy_len > 0) begin
      busy_cnt      <= busy_len - 1;
      bus.uart_busy <= 1'b1;
    end else begin
      bus.uart_busy <= busy_hold || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.uart_start === 1'b1) begin
      tx_q.push_back(bus.uart_data);
      tx_t.push_back(cyc);
    end
  end

  task automatic drive(input int p, input bit v, input logic [7:0] d, input bit l);
    if (p == 0) begin
      bus.s0_valid = v; bus.s0_data = d; bus.s0_last = l;
    end else begin
      bus.s1_valid = v; bus.s1_data = d; bus.s1_last = l;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.s0_ready : bus.s1_ready;
  endfunction

  task automatic send_pkt(input int p, input logic [7:0] first, input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      @(negedge clk);
      drive(p, 1'b1, 8'(first + i), use_last && (i == n - 1));
      #1;
      while (rdy(p) !== 1'b1 && w < 3000) begin
        @(negedge clk); #1; w++;
      end
      checks++;
      if (w >= 3000) begin
        failures++;
        $display("FAIL send_timeout port=%0d byte=%h got=stalled exp=accepted", p, 8'(first + i));
      end
      @(posedge clk);
    end
    @(negedge clk);
    drive(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    @(negedge clk); #1;
    while (!(idle === 1'b1 && bus.uart_busy === 1'b0) && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s_drain got=busy exp=idle", nm);
    end
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    busy_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tx_q.delete();
    tx_t.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    checks++; if (bus.uart_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", bus.uart_start); end
    checks++; if (bus.uart_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", bus.uart_data); end
    checks++; if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b%b exp=00", bus.s0_ready, bus.s1_ready); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    do_reset();
    busy_len = 100;
    @(negedge clk);
    drive(0, 1'b1, 8'h41, 1'b1);
    #1;
    checks++; if (bus.s0_ready !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", bus.s0_ready); end
    @(posedge clk); #1;
    checks++; if (fifo_count !== 4'd1 || bus.uart_start !== 1'b0) begin failures++; $display("FAIL t1_edge_n got=cnt%0d/st%b exp=cnt1/st0", fifo_count, bus.uart_start); end
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    checks++; if (bus.uart_start !== 1'b1 || bus.uart_data !== 8'h41 || fifo_count !== 4'd0) begin failures++; $display("FAIL t1_launch got=st%b/d%h/cnt%0d exp=st1/d41/cnt0", bus.uart_start, bus.uart_data, fifo_count); end
    @(posedge clk); #1;
    checks++; if (bus.uart_start !== 1'b0 || bus.uart_data !== 8'h41) begin failures++; $display("FAIL t1_pulse got=st%b/d%h exp=st0/d41", bus.uart_start, bus.uart_data); end
    repeat (50) @(negedge clk);
    #1;
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL t1_busy_idle got=%b exp=0", idle); end
    wait_drain("t1");
    checks++; if (tx_q.size() != 1) begin failures++; $display("FAIL t1_starts got=%0d exp=1", tx_q.size()); end
    checks++; if (tx_q.size() > 0 && tx_q[0] !== 8'h41) begin failures++; $display("FAIL t1_byte got=%h exp=41", tx_q[0]); end
  endtask

  task automatic test_contention();
    logic [7:0] exp [6] = '{8'h10, 8'h11, 8'h20, 8'h30, 8'h50, 8'h40};
    do_reset();
    busy_len = 4;
    fork
      send_pkt(0, 8'h10, 2, 1'b1);
      send_pkt(1, 8'h20, 1, 1'b1);
    join
    wait_drain("t2a");
    send_pkt(0, 8'h30, 1, 1'b1);
    wait_drain("t2b");
    fork
      send_pkt(0, 8'h40, 1, 1'b1);
      send_pkt(1, 8'h50, 1, 1'b1);
    join
    wait_drain("t2c");
    checks++; if (tx_q.size() != 6) begin failures++; $display("FAIL t2_len got=%0d exp=6", tx_q.size()); end
    for (int i = 0; i < 6 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp[i]) begin failures++; $display("FAIL t2_order[%0d] got=%h exp=%h", i, tx_q[i], exp[i]); end
    end
  endtask

  task automatic test_full();
    do_reset();
    busy_len = 3;
    busy_hold = 1'b1;
    fork
      send_pkt(0, 8'h60, 10, 1'b1);
      begin
        int n = 0;
        while (fifo_count !== 4'd8 && n < 300) begin @(negedge clk); #1; n++; end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL t3_full_count got=%0d exp=8", fifo_count); end
        checks++; if (bus.s0_ready !== 1'b0) begin failures++; $display("FAIL t3_full_ready got=%b exp=0", bus.s0_ready); end
        checks++; if (tx_q.size() != 1) begin failures++; $display("FAIL t3_held_starts got=%0d exp=1", tx_q.size()); end
        busy_hold = 1'b0;
      end
    join
    wait_drain("t3");
    checks++; if (tx_q.size() != 10) begin failures++; $display("FAIL t3_len got=%0d exp=10", tx_q.size()); end
    for (int i = 0; i < 10 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== 8'(8'h60 + i)) begin failures++; $display("FAIL t3_order[%0d] got=%h exp=%h", i, tx_q[i], 8'(8'h60 + i)); end
    end
  endtask

  task automatic test_push_pop_wrap();
    int n = 0;
    do_reset();
    busy_len = 2;
    busy_hold = 1'b1;
    send_pkt(0, 8'h00, 4, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL t4_pre_count got=%0d exp=3", fifo_count); end
    busy_hold = 1'b0;
    while (bus.uart_busy !== 1'b0 && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 8'h04, 1'b0);
    #1;
    checks++; if (bus.s0_ready !== 1'b1) begin failures++; $display("FAIL t4_ready got=%b exp=1", bus.s0_ready); end
    @(posedge clk); #1;
    checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL t4_pushpop_count got=%0d exp=3", fifo_count); end
    checks++; if (bus.uart_start !== 1'b1) begin failures++; $display("FAIL t4_pushpop_start got=%b exp=1", bus.uart_start); end
    send_pkt(0, 8'h05, 15, 1'b1);
    wait_drain("t4");
    checks++; if (tx_q.size() != 20) begin failures++; $display("FAIL t4_len got=%0d exp=20", tx_q.size()); end
    for (int i = 0; i < 20 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== 8'(i)) begin failures++; $display("FAIL t4_order[%0d] got=%h exp=%h", i, tx_q[i], 8'(i)); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    busy_len = 0;
    send_pkt(0, 8'h70, 2, 1'b1);
    while (tx_q.size() < 2 && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (tx_q.size() < 2) begin
      failures++; $display("FAIL t5_second_start got=%0d exp=2", tx_q.size());
    end else begin
      checks++; if (tx_t[1] - tx_t[0] != 17) begin failures++; $display("FAIL t5_gap got=%0d exp=17", tx_t[1] - tx_t[0]); end
      checks++; if (tx_q[0] !== 8'h70 || tx_q[1] !== 8'h71) begin failures++; $display("FAIL t5_bytes got=%h%h exp=7071", tx_q[0], tx_q[1]); end
      n = 0;
      while (idle !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      checks++; if (cyc - tx_t[1] != 16) begin failures++; $display("FAIL t5_idle_after got=%0d exp=16", cyc - tx_t[1]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    busy_len = 50;
    send_pkt(0, 8'h80, 4, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (fifo_count !== 4'd3 || bus.uart_busy !== 1'b1) begin failures++; $display("FAIL t6_pre got=cnt%0d/busy%b exp=cnt3/busy1", fifo_count, bus.uart_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL t6_count got=%0d exp=0", fifo_count); end
    checks++; if (bus.uart_start !== 1'b0) begin failures++; $display("FAIL t6_start got=%b exp=0", bus.uart_start); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL t6_idle got=%b exp=1", idle); end
    repeat (2) @(negedge clk);
    tx_q.delete();
    tx_t.delete();
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 1'b1, 8'h90, 1'b1);
    #1;
    checks++; if (bus.s1_ready !== 1'b1) begin failures++; $display("FAIL t6_s1_grant got=%b exp=1", bus.s1_ready); end
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_drain("t6");
    checks++; if (tx_q.size() != 1 || (tx_q.size() > 0 && tx_q[0] !== 8'h90)) begin failures++; $display("FAIL t6_tx got=%0d bytes exp=1 byte 90", tx_q.size()); end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    test_reset();
    test_single_byte();
    test_contention();
    test_full();
    test_push_pop_wrap();
    test_timeout();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
